// File: rtl/led_water_pkg.sv
// Shared encodings, FSM states and seed helpers for the LED water-flow pattern engine.
package led_water_pkg;

  localparam logic [1:0] MODE_SHIFT_L  = 2'b00;
  localparam logic [1:0] MODE_SHIFT_R  = 2'b01;
  localparam logic [1:0] MODE_PINGPONG = 2'b10;
  localparam logic [1:0] MODE_FILL     = 2'b11;

  localparam int unsigned MAX_LED_W = 64;

  typedef enum logic [2:0] {
    S_SHL,
    S_SHR,
    S_PP_UP,
    S_PP_DN,
    S_FILL
  } state_e;

  // Seed pattern shown on entry to a mode: SHIFT_R starts at the MSB, all others at bit 0.
  function automatic logic [MAX_LED_W-1:0] seed_of(input logic [1:0] mode,
                                                   input int unsigned width);
    seed_of = MAX_LED_W'(1);
    if (mode == MODE_SHIFT_R) begin
      seed_of = MAX_LED_W'(1) << (width - 1);
    end
  endfunction

  function automatic state_e entry_state(input logic [1:0] mode);
    case (mode)
      MODE_SHIFT_R:  entry_state = S_SHR;
      MODE_PINGPONG: entry_state = S_PP_UP;
      MODE_FILL:     entry_state = S_FILL;
      default:       entry_state = S_SHL;
    endcase
  endfunction

  function automatic logic [1:0] mode_of(input state_e s);
    case (s)
      S_SHR:           mode_of = MODE_SHIFT_R;
      S_PP_UP, S_PP_DN: mode_of = MODE_PINGPONG;
      S_FILL:          mode_of = MODE_FILL;
      default:         mode_of = MODE_SHIFT_L;
    endcase
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for a level sampled in the local clock domain; history resets high.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic pulse
);

  logic sig_d_q;
  logic sig_d_d;

  always_comb begin
    sig_d_d = sig;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_d_q <= 1'b1;
    end else begin
      sig_d_q <= sig_d_d;
    end
  end

  assign pulse = sig & ~sig_d_q;

endmodule

// File: rtl/led_water_ctrl.sv
// LED water-flow pattern engine: advances one of four patterns on each rising edge of CLK_1HZ.
import led_water_pkg::*;

module led_water_ctrl #(
  parameter int unsigned LED_WIDTH      = 8,
  parameter bit          LED_ACTIVE_LOW = 1'b0
) (
  input  logic                 CLK_50MHZ,
  input  logic                 RST,
  input  logic                 CLK_1HZ,
  input  logic [1:0]           MODE,
  input  logic                 PAUSE,
  output logic [LED_WIDTH-1:0] LED,
  output logic                 WRAP
);

  localparam int unsigned MSB = LED_WIDTH - 1;
  localparam logic [LED_WIDTH-1:0] ALL_ONES = '1;

  logic [1:0]           mode_meta_q, mode_meta_d, mode_s_q, mode_s_d;
  logic                 pause_meta_q, pause_meta_d, pause_s_q, pause_s_d;
  state_e               state_q, state_d;
  logic [LED_WIDTH-1:0] p_q, p_d;
  logic                 wrap_q, wrap_d;
  logic                 step_c;
  logic                 legal_c;
  logic [1:0]           mode_cur_c;

  rise_detect u_step (
    .clk   (CLK_50MHZ),
    .rst   (RST),
    .sig   (CLK_1HZ),
    .pulse (step_c)
  );

  always_comb begin
    mode_meta_d  = MODE;
    mode_s_d     = mode_meta_q;
    pause_meta_d = PAUSE;
    pause_s_d    = pause_meta_q;
  end

  // Pattern legality: one-hot outside FILL (and not already at the turning end for PINGPONG),
  // contiguous low ones (including zero) in FILL.
  always_comb begin
    legal_c = 1'b0;
    case (state_q)
      S_SHL, S_SHR: legal_c = $onehot(p_q);
      S_PP_UP:      legal_c = $onehot(p_q) && !p_q[MSB];
      S_PP_DN:      legal_c = $onehot(p_q) && !p_q[0];
      S_FILL:       legal_c = ((p_q & (p_q + LED_WIDTH'(1))) == '0);
      default:      legal_c = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    p_d        = p_q;
    wrap_d     = 1'b0;
    mode_cur_c = mode_of(state_q);
    if (step_c && !pause_s_q) begin
      if (mode_s_q != mode_cur_c) begin
        state_d = entry_state(mode_s_q);
        p_d     = LED_WIDTH'(seed_of(mode_s_q, LED_WIDTH));
      end else if (!legal_c) begin
        state_d = entry_state(mode_cur_c);
        p_d     = LED_WIDTH'(seed_of(mode_cur_c, LED_WIDTH));
      end else begin
        case (state_q)
          S_SHL: begin
            p_d    = {p_q[MSB-1:0], p_q[MSB]};
            wrap_d = p_q[MSB];
          end
          S_SHR: begin
            p_d    = {p_q[0], p_q[MSB:1]};
            wrap_d = p_q[0];
          end
          S_PP_UP: begin
            p_d = p_q << 1;
            if (p_q[MSB-1]) state_d = S_PP_DN;
          end
          S_PP_DN: begin
            p_d = p_q >> 1;
            if (p_q[1]) begin
              state_d = S_PP_UP;
              wrap_d  = 1'b1;
            end
          end
          S_FILL: begin
            if (p_q == ALL_ONES) begin
              p_d    = '0;
              wrap_d = 1'b1;
            end else begin
              p_d = (p_q << 1) | LED_WIDTH'(1);
            end
          end
          default: begin
            state_d = S_SHL;
            p_d     = LED_WIDTH'(1);
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLK_50MHZ) begin
    if (RST) begin
      mode_meta_q  <= 2'b00;
      mode_s_q     <= 2'b00;
      pause_meta_q <= 1'b0;
      pause_s_q    <= 1'b0;
      state_q      <= S_SHL;
      p_q          <= LED_WIDTH'(1);
      wrap_q       <= 1'b0;
    end else begin
      mode_meta_q  <= mode_meta_d;
      mode_s_q     <= mode_s_d;
      pause_meta_q <= pause_meta_d;
      pause_s_q    <= pause_s_d;
      state_q      <= state_d;
      p_q          <= p_d;
      wrap_q       <= wrap_d;
    end
  end

  // Polarity is a static inversion of the pattern register.
  assign LED  = LED_ACTIVE_LOW ? ~p_q : p_q;
  assign WRAP = wrap_q;

endmodule

// File: tb/tb_led_water_ctrl.sv
// Bench for led_water_ctrl: directed and random steps against a phase-based reference model.
module tb_led_water_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_1hz = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       pause = 1'b0;
  logic [7:0] led, led_n;
  logic       wrap, wrap_n;

  int total = 0;
  int bad = 0;

  logic [1:0] mode_m;
  int         phase_m;
  logic       wrap_m;

  always #5 clk = ~clk;

  led_water_ctrl #(.LED_WIDTH(8), .LED_ACTIVE_LOW(1'b0)) dut (
    .CLK_50MHZ (clk),
    .RST       (rst),
    .CLK_1HZ   (clk_1hz),
    .MODE      (mode),
    .PAUSE     (pause),
    .LED       (led),
    .WRAP      (wrap)
  );

  led_water_ctrl #(.LED_WIDTH(8), .LED_ACTIVE_LOW(1'b1)) dut_n (
    .CLK_50MHZ (clk),
    .RST       (rst),
    .CLK_1HZ   (clk_1hz),
    .MODE      (mode),
    .PAUSE     (pause),
    .LED       (led_n),
    .WRAP      (wrap_n)
  );

  function automatic int period_of(input logic [1:0] m);
    case (m)
      2'b10:   period_of = 14;
      2'b11:   period_of = 9;
      default: period_of = 8;
    endcase
  endfunction

  // LED value of a mode at a given phase of its period.
  function automatic logic [7:0] value_of(input logic [1:0] m, input int ph);
    int pos;
    case (m)
      2'b00: value_of = 8'(1) << ph;
      2'b01: value_of = 8'h80 >> ph;
      2'b10: begin
        pos      = (ph < 8) ? ph : 14 - ph;
        value_of = 8'(1) << pos;
      end
      default: value_of = 8'((9'(1) << ph) - 9'(1));
    endcase
  endfunction

  task automatic model_reset();
    mode_m  = 2'b00;
    phase_m = 0;
    wrap_m  = 1'b0;
  endtask

  task automatic model_step();
    wrap_m = 1'b0;
    if (!pause) begin
      if (mode != mode_m) begin
        mode_m  = mode;
        phase_m = (mode == 2'b11) ? 1 : 0;
      end else begin
        phase_m = (phase_m + 1) % period_of(mode_m);
        wrap_m  = (phase_m == 0);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_led"}, led, value_of(mode_m, phase_m));
    chk({tag, "_led_n"}, led_n, ~value_of(mode_m, phase_m));
    chk({tag, "_wrap"}, 8'(wrap), 8'(wrap_m));
    chk({tag, "_wrap_n"}, 8'(wrap_n), 8'(wrap_m));
  endtask

  // One short CLK_1HZ pulse after the synchronizers have settled.
  task automatic do_step(input string tag);
    repeat (3) @(negedge clk);
    clk_1hz = 1'b1;
    model_step();
    @(negedge clk);
    chk_all(tag);
    clk_1hz = 1'b0;
    wrap_m  = 1'b0;
    @(negedge clk);
    chk_all({tag, "_after"});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_all("reset");

    mode = 2'b00;
    for (int i = 0; i < 8; i++) do_step("shl");

    mode = 2'b10;
    for (int i = 0; i < 15; i++) do_step("pp");

    mode = 2'b11;
    for (int i = 0; i < 10; i++) do_step("fill");

    pause = 1'b1;
    for (int i = 0; i < 3; i++) do_step("paused");
    pause = 1'b0;
    do_step("unpaused");
    chk("unpaused_val", led, 8'h03);

    @(negedge clk);
    clk_1hz = 1'b1;
    do_reset();
    repeat (4) begin
      @(negedge clk);
      chk_all("held_high");
    end
    clk_1hz = 1'b0;

    mode = 2'b10;
    for (int i = 0; i < 6; i++) do_step("pp_run");
    chk("pp_at_20", led, 8'h20);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk_all("mid_reset");
    mode = 2'b00;
    do_step("post_reset_shl");
    chk("post_reset_val", led, 8'h02);

    do_reset();
    mode = 2'b01;
    do_step("shr_seed");
    chk("active_low_seed", led_n, 8'h7F);
    @(negedge clk);
    mode = 2'b10;
    repeat (5) @(negedge clk);
    chk_all("toggle_hold");
    mode = 2'b01;
    do_step("shr_adv");
    chk("shr_adv_val", led, 8'h40);

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) mode = 2'($urandom_range(0, 3));
      pause = ($urandom_range(0, 4) == 0);
      do_step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
